// File: rtl/windowed_reg_file_pkg.sv
// Shared encodings and constants for the windowed SPARC integer register file.
package sparc_rf_pkg;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'b00,
        WIN_SAVE    = 2'b01,
        WIN_RESTORE = 2'b10,
        WIN_RSVD    = 2'b11
    } win_op_e;

    localparam int NGLOBALS = 8;
    localparam int WIN_REGS = 16;

endpackage

// File: rtl/windowed_reg_file_if.sv
// Bus between decode/write-back and the windowed register file.
interface windowed_reg_file_if #(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8
);
    localparam int CWP_W = $clog2(NWINDOWS);

    logic [4:0]          rd_addr_a;
    logic [DATA_W-1:0]   rd_data_a;
    logic [4:0]          rd_addr_b;
    logic [DATA_W-1:0]   rd_data_b;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [1:0]          win_op;
    logic [NWINDOWS-1:0] wim;
    logic [CWP_W-1:0]    cwp;
    logic                trap_ovf;
    logic                trap_unf;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, win_op, wim,
        input  rd_data_a, rd_data_b, cwp, trap_ovf, trap_unf
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, win_op, wim,
        output rd_data_a, rd_data_b, cwp, trap_ovf, trap_unf
    );
endinterface

// File: rtl/windowed_reg_file_win_map.sv
// Architectural (addr, cwp) to physical index translation; globals bypass the window.
module rf_win_map
    import sparc_rf_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS),
    parameter int PHYS_W   = $clog2(NGLOBALS + WIN_REGS * NWINDOWS)
) (
    input  logic [4:0]        addr,
    input  logic [CWP_W-1:0]  cwp,
    output logic [PHYS_W-1:0] phys
);
    localparam int unsigned SPAN = WIN_REGS * NWINDOWS;

    int unsigned off;

    // Windowed offset wraps once at most, so a single conditional subtract is an exact modulo.
    always_comb begin
        off  = '0;
        phys = PHYS_W'(addr);
        if (addr >= 5'(NGLOBALS)) begin
            off = (32'(cwp) << 4) + 32'(addr) - 32'(NGLOBALS);
            if (off >= SPAN) begin
                off = off - SPAN;
            end
            phys = PHYS_W'(off + 32'(NGLOBALS));
        end
    end
endmodule

// File: rtl/windowed_reg_file.sv
// Windowed SPARC integer register file with CWP/WIM trap logic.
// Define RF_BYPASS_EN to forward same-cycle write data to matching reads.
module windowed_reg_file
    import sparc_rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NWINDOWS = 8
) (
    input logic          clk,
    input logic          reset,
    windowed_reg_file_if.slave bus
);
    localparam int NPHYS  = NGLOBALS + WIN_REGS * NWINDOWS;
    localparam int CWP_W  = $clog2(NWINDOWS);
    localparam int PHYS_W = $clog2(NPHYS);

    logic [DATA_W-1:0] regs_q [NPHYS];
    logic [DATA_W-1:0] regs_d [NPHYS];
    logic [CWP_W-1:0]  cwp_q, cwp_d, cwp_dec, cwp_inc;
    logic              trap_ovf_q, trap_ovf_d;
    logic              trap_unf_q, trap_unf_d;
    logic [PHYS_W-1:0] rd_phys_a, rd_phys_b, wr_phys;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              wr_hit;
    win_op_e           op;

    rf_win_map #(.NWINDOWS(NWINDOWS)) u_map_a  (.addr(bus.rd_addr_a), .cwp(cwp_q), .phys(rd_phys_a));
    rf_win_map #(.NWINDOWS(NWINDOWS)) u_map_b  (.addr(bus.rd_addr_b), .cwp(cwp_q), .phys(rd_phys_b));
    rf_win_map #(.NWINDOWS(NWINDOWS)) u_map_wr (.addr(bus.wr_addr),   .cwp(cwp_q), .phys(wr_phys));

    assign wr_hit = bus.wr_en && (bus.wr_addr != 5'd0);

    always_comb begin
        rd_data_a = (bus.rd_addr_a == 5'd0) ? '0 : regs_q[rd_phys_a];
        rd_data_b = (bus.rd_addr_b == 5'd0) ? '0 : regs_q[rd_phys_b];
`ifdef RF_BYPASS_EN
        if (wr_hit && (bus.rd_addr_a != 5'd0) && (rd_phys_a == wr_phys)) begin
            rd_data_a = bus.wr_data;
        end
        if (wr_hit && (bus.rd_addr_b != 5'd0) && (rd_phys_b == wr_phys)) begin
            rd_data_b = bus.wr_data;
        end
`else
`endif
    end

    // The write is translated with the pre-op window, so it lands in the old window.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_phys] = bus.wr_data;
        end
    end

    always_comb begin
        op         = win_op_e'(bus.win_op);
        cwp_dec    = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - CWP_W'(1);
        cwp_inc    = (cwp_q == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_q + CWP_W'(1);
        cwp_d      = cwp_q;
        trap_ovf_d = 1'b0;
        trap_unf_d = 1'b0;
        case (op)
            WIN_SAVE: begin
                if (bus.wim[cwp_dec]) trap_ovf_d = 1'b1;
                else                  cwp_d      = cwp_dec;
            end
            WIN_RESTORE: begin
                if (bus.wim[cwp_inc]) trap_unf_d = 1'b1;
                else                  cwp_d      = cwp_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q     <= '{default: '0};
            cwp_q      <= '0;
            trap_ovf_q <= 1'b0;
            trap_unf_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            cwp_q      <= cwp_d;
            trap_ovf_q <= trap_ovf_d;
            trap_unf_q <= trap_unf_d;
        end
    end

    assign bus.rd_data_a = rd_data_a;
    assign bus.rd_data_b = rd_data_b;
    assign bus.cwp       = cwp_q;
    assign bus.trap_ovf  = trap_ovf_q;
    assign bus.trap_unf  = trap_unf_q;
endmodule

// File: tb/tb_windowed_reg_file.sv
// Bench for windowed_reg_file: directed scenarios plus random traffic against an array model.
module tb_windowed_reg_file;
    localparam int NW    = 8;
    localparam int NPHYS = 8 + 16 * NW;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   check_en;

    logic [31:0] mem [NPHYS];
    int          m_cwp;
    logic        m_ovf, m_unf;

    windowed_reg_file_if #(.DATA_W(32), .NWINDOWS(NW)) bus ();

    windowed_reg_file #(.DATA_W(32), .NWINDOWS(NW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int phys_of(input int r, input int w);
        if (r < 8) return r;
        return 8 + ((16 * w + r - 8) % (16 * NW));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (bus.wr_en && bus.wr_addr != 5'd0 &&
            phys_of(int'(a), m_cwp) == phys_of(int'(bus.wr_addr), m_cwp))
            return bus.wr_data;
`endif
        return mem[phys_of(int'(a), m_cwp)];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules applied on each rising edge.
    always @(posedge clk) begin
        int t;
        if (reset) begin
            for (int i = 0; i < NPHYS; i++) mem[i] = 32'd0;
            m_cwp = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (bus.wr_en && bus.wr_addr != 5'd0)
                mem[phys_of(int'(bus.wr_addr), m_cwp)] = bus.wr_data;
            if (bus.win_op == 2'b01) begin
                t = (m_cwp + NW - 1) % NW;
                if (bus.wim[t]) m_ovf = 1'b1;
                else            m_cwp = t;
            end else if (bus.win_op == 2'b10) begin
                t = (m_cwp + 1) % NW;
                if (bus.wim[t]) m_unf = 1'b1;
                else            m_cwp = t;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cwp",      32'(bus.cwp),      32'(m_cwp));
            checkOutput("trap_ovf", 32'(bus.trap_ovf), 32'(m_ovf));
            checkOutput("trap_unf", 32'(bus.trap_unf), 32'(m_unf));
            checkOutput("rd_a",     bus.rd_data_a,     model_read(bus.rd_addr_a));
            checkOutput("rd_b",     bus.rd_data_b,     model_read(bus.rd_addr_b));
        end
    end

    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [1:0] op,
                                 input logic [7:0] wv, input logic [4:0] ra, input logic [4:0] rb);
        reset         = rst;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.win_op    = op;
        bus.wim       = wv;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.wr_en  = 1'b0;
        bus.win_op = 2'b00;
    endtask

    task automatic checkRead(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.rd_addr_a = a;
        #1;
        checkOutput(name, bus.rd_data_a, exp);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 8'h00, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 8'h00, 5'd0, 5'd0);
        nextCycle();
        check_en = 1'b1;
        checkOutput("rst_cwp", 32'(bus.cwp), 32'd0);
        checkOutput("rst_ovf", 32'(bus.trap_ovf), 32'd0);
        checkOutput("rst_unf", 32'(bus.trap_unf), 32'd0);

        for (int w = 0; w < NW; w++) begin
            for (int r = 1; r < 32; r += 2) begin
                applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 8'h00, 5'(r), 5'(r + 1));
                checkOutput("rst_rd_a", bus.rd_data_a, 32'd0);
                checkOutput("rst_rd_b", bus.rd_data_b, 32'd0);
                nextCycle();
            end
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd0, 5'd0);
            nextCycle();
        end
        checkOutput("wrap8_cwp", 32'(bus.cwp), 32'd0);

        applyStimulus(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 2'b00, 8'h00, 5'd8, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd8, 5'd0);
        nextCycle();
        checkOutput("save_cwp", 32'(bus.cwp), 32'd7);
        checkRead("alias_r24", 5'd24, 32'hDEADBEEF);
        checkRead("new_r8", 5'd8, 32'd0);

        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b10, 8'h00, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h80, 5'd0, 5'd0);
        nextCycle();
        checkOutput("ovf_pulse", 32'(bus.trap_ovf), 32'd1);
        checkOutput("ovf_cwp", 32'(bus.cwp), 32'd0);
        nextCycle();
        checkOutput("ovf_clear", 32'(bus.trap_ovf), 32'd0);

        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b10, 8'h01, 5'd0, 5'd0);
        nextCycle();
        checkOutput("unf_pulse", 32'(bus.trap_unf), 32'd1);
        checkOutput("unf_cwp", 32'(bus.cwp), 32'd7);
        nextCycle();
        checkOutput("unf_clear", 32'(bus.trap_unf), 32'd0);

        applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 2'b00, 8'h00, 5'd0, 5'd0);
        nextCycle();
        checkRead("r0_zero", 5'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 2'b00, 8'h00, 5'd5, 5'd0);
        nextCycle();
        for (int i = 0; i < NW; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd5, 5'd0);
            nextCycle();
            checkRead("global_r5", 5'd5, 32'hA5A5A5A5);
        end
        checkOutput("wrap_back_cwp", 32'(bus.cwp), 32'd7);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd0, 5'd0);
            nextCycle();
        end
        checkOutput("at3_cwp", 32'(bus.cwp), 32'd3);
        applyStimulus(1'b0, 1'b1, 5'd16, 32'h55, 2'b10, 8'h00, 5'd16, 5'd0);
        nextCycle();
        checkOutput("wr_restore_cwp", 32'(bus.cwp), 32'd4);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 8'h00, 5'd16, 5'd0);
        nextCycle();
        checkRead("old_win_r16", 5'd16, 32'h55);

        applyStimulus(1'b0, 1'b1, 5'd9, 32'h77, 2'b00, 8'h00, 5'd9, 5'd9);
`ifdef RF_BYPASS_EN
        checkOutput("bypass_r9", bus.rd_data_a, 32'h77);
`else
        checkOutput("bypass_r9", bus.rd_data_a, 32'h0);
`endif
        nextCycle();
        checkRead("after_r9", 5'd9, 32'h77);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 2'b10, 8'h00, 5'd9, 5'd16);
            nextCycle();
        end
        checkOutput("at5_cwp", 32'(bus.cwp), 32'd5);
        applyStimulus(1'b1, 1'b1, 5'd10, 32'hFFFF, 2'b01, 8'h00, 5'd5, 5'd16);
        nextCycle();
        checkOutput("midrst_cwp", 32'(bus.cwp), 32'd0);
        checkRead("midrst_r5", 5'd5, 32'd0);
        checkRead("midrst_r8", 5'd8, 32'd0);

        for (int i = 0; i < 2500; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom);
            applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                          2'($urandom_range(0, 3)), 8'($urandom & $urandom & $urandom),
                          5'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
            nextCycle();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
